display_mux_n: RTL
==================

# display_mux_n

Parametrised multiplexed seven-segment display driver for the Nexys 4 board display path. It scans NDIGITS common-anode digits from a double-buffered hex value and has per-digit decimal points, per-digit blanking and PWM brightness control. It also emits a frame-start pulse so upstream logic can change the value between scans. It sits between the CPU's debug/result register and the board's segment and anode pins, and uses hexto7seg for nibble decoding.

## Interface
- NDIGITS, 8, number of digits scanned (1..16; need not be a power of two)
- PRESCALE_BITS, 17, each digit slot lasts 2^PRESCALE_BITS clocks
- BRIGHT_BITS, 4, brightness resolution (must be ≤ PRESCALE_BITS)

Ports (the clock is `clock`; the reset is `reset`, synchronous and active-high):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- val  in  4*NDIGITS  hex value; nibble i drives digit i (digit 0 is rightmost)
- dp  in  NDIGITS  decimal point per digit, 1 = lit
- blank  in  NDIGITS  per-digit blank, 1 = digit dark
- load  in  1  capture val, dp and blank into shadow registers
- brightness  in  BRIGHT_BITS  duty level; 0 = minimum, all-ones = full
- segments  out  8  active-low; [6:0] taken from hexto7seg output [6:0], [7] = decimal point
- digitselect  out  NDIGITS  active-low, one-cold anode enables
- frame  out  1  one-cycle pulse at the start of the digit-0 slot

## Operation
- Shadow registers sv, sdp and sblank are loaded on any clock edge where load=1. The display always shows the shadow contents and never the live inputs.
- Prescaler `pre` (PRESCALE_BITS wide) increments every clock.
- When `pre` is all-ones, digit index `idx` advances: idx = (idx == NDIGITS-1) ? 0 : idx+1.
- Digit on-window condition: pre[PRESCALE_BITS-1 -: BRIGHT_BITS] ≤ brightness.
  - brightness = all-ones gives 100% duty.
  - brightness = 0 gives a duty of 1/2^BRIGHT_BITS.
  - brightness is sampled live; a change takes effect on the next cycle.
- A digit is active when it is in its on-window and sblank[idx] = 0 (and it is not suppressed; see Configuration).
- Active digit outputs:
  - digitselect = ~(1 << idx).
  - segments[6:0] = hexto7seg(sv[4*idx +: 4])[6:0].
  - segments[7] = ~sdp[idx].
- Inactive digit outputs: digitselect = all-ones and segments = 8'hFF.
- frame = 1 for exactly one cycle, at the first cycle of the registered digit-0 slot.
- Reset values:
  - pre = 0 and idx = 0.
  - sv = 0, sdp = 0, sblank = all-ones.
  - Outputs: segments = 8'hFF, digitselect = all-ones, frame = 0.
  - The display is therefore dark until the first load.

## Timing
- All outputs are registered, with a latency of 1 clock from the internal pre/idx/shadow state.
- load at edge N: the new shadow value is visible on the outputs from edge N+2.
- A load that coincides with an idx advance is used by the new slot (still from N+2).
- idx advance: the last cycle of a slot is pre = all-ones. The outputs for the next digit appear one cycle after the advance edge.
- Reset is synchronous. Asserting it mid-scan forces all reset values on the next edge, regardless of load.
- The first frame pulse after reset release occurs 1 cycle after release.
- With load held high, the shadow tracks the inputs every cycle (with 1-cycle staleness).

## Configuration
- DISPLAY_LZS_EN selects leading-zero suppression.
- Defined:
  - A digit i > 0 is suppressed (dark, dp also dark) when sv nibbles i..NDIGITS-1 are all zero and no sdp bit in i..NDIGITS-1 is set.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from the shadow registers, adding no extra latency.
- Undefined: all non-blanked digits are always shown, including leading zeros.

## Test plan
1. Run with NDIGITS=8, PRESCALE_BITS=3, BRIGHT_BITS=2 and brightness=3. Release reset, then load val=32'h1234ABCD, dp=0, blank=0.
   - digitselect cycles FE, FD, FB, …, 7F for 8 cycles each.
   - Digit 0 shows hexto7seg(D) with segments[7]=1.
   - Digit 7 shows hexto7seg(1).
   - frame pulses every 64 cycles.
2. Run with NDIGITS=6, PRESCALE_BITS=3.
   - idx wraps 5→0 with no 7-digit slot.
   - digitselect is only ever one of the 6 one-cold values or all-ones.
   - frame period is 48 cycles.
3. Set brightness=0 with BRIGHT_BITS=2, PRESCALE_BITS=3.
   - Each slot is active for exactly 2 of 8 cycles (pre=0,1) and dark for 6.
   - Changing brightness to 2 gives 6 active cycles from the next slot onward.
4. Load blank=8'h04 and dp=8'h01.
   - Digit 2 slot: digitselect=FF.
   - Digit 0: segments[7]=0.
   - Before any load after reset: digitselect stays all-ones.
5. With DISPLAY_LZS_EN defined:
   - val=32'h00000420 → digits 7..3 dark; digits 2,1,0 show 4,2,0.
   - val=0 → only digit 0 shows 0.
   - val=0 with dp=8'h10 → digits 4..0 are shown.
6. Reset mid-operation: assert reset for 1 cycle during the digit-5 slot.
   - Next edge: outputs dark, idx=0, shadow cleared.
   - A reload restores scanning starting from digit 0 with a frame pulse.

Source files
------------

// File: rtl/display_mux_n.sv
// Multiplexed common-anode seven-segment driver with double-buffered value, per-digit dp/blank and PWM brightness.
// Define DISPLAY_LZS_EN to enable leading-zero suppression.
module display_mux_n #(
  parameter int NDIGITS       = 8,
  parameter int PRESCALE_BITS = 17,
  parameter int BRIGHT_BITS   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   val,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   load,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [7:0]             segments,
  output logic [NDIGITS-1:0]     digitselect,
  output logic                   frame
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [4*NDIGITS-1:0]   sv;
  logic [NDIGITS-1:0]     sdp;
  logic [NDIGITS-1:0]     sblank;
  logic [PRESCALE_BITS-1:0] pre;
  logic [IW-1:0]          idx;
  logic [NDIGITS-1:0]     suppress;

  logic [3:0] curnib;
  logic       curdp;
  logic       curblank;
  logic       cursupp;
  logic       onwindow;
  logic       active;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hexto7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sv     <= '0;
      sdp    <= '0;
      sblank <= '1;
    end else if (load) begin
      sv     <= val;
      sdp    <= dp;
      sblank <= blank;
    end
  end

  // Slot timing: idx moves on the last cycle of each slot, wrapping at NDIGITS-1
  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (&pre) begin
        idx <= (idx == IW'(NDIGITS-1)) ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef DISPLAY_LZS_EN
  // Walk from the top digit down; a digit is suppressed while everything at and above it is zero with no dp
  always_comb begin
    logic zeroabove;
    zeroabove = 1'b1;
    suppress  = '0;
    for (int i = NDIGITS-1; i >= 0; i--) begin
      zeroabove   = zeroabove & (sv[4*i +: 4] == 4'h0) & ~sdp[i];
      suppress[i] = (i != 0) && zeroabove;
    end
  end
`else
  assign suppress = '0;
`endif

  always_comb begin
    curnib   = 4'h0;
    curdp    = 1'b0;
    curblank = 1'b1;
    cursupp  = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        curnib   = sv[4*i +: 4];
        curdp    = sdp[i];
        curblank = sblank[i];
        cursupp  = suppress[i];
      end
    end
  end

  assign onwindow = (pre[PRESCALE_BITS-1 -: BRIGHT_BITS] <= brightness);
  assign active   = onwindow & ~curblank & ~cursupp;

  always_ff @(posedge clock) begin
    if (reset) begin
      segments    <= 8'hFF;
      digitselect <= '1;
      frame       <= 1'b0;
    end else begin
      frame <= (idx == '0) && (pre == '0);
      if (active) begin
        digitselect <= ~(NDIGITS'(1) << idx);
        segments    <= {~curdp, hexto7seg(curnib)};
      end else begin
        digitselect <= '1;
        segments    <= 8'hFF;
      end
    end
  end

endmodule
